pwm_button_conditioner: RTL and testbench

- Upstream stage of the PWM duty-cycle controller: turns the raw increase/decrease push-button inputs into clean single-cycle `duty_inc` / `duty_dec` command pulses.
- Performs 2-FF synchronisation, tick-based debouncing, press-edge detection, hold-to-auto-repeat, and conflict lockout when both buttons are held.
- Outputs connect directly to the controller's duty_inc/duty_dec inputs, replacing its ad-hoc debounce flops.

---
 rtl/pwm_button_conditioner.sv | 217 +++++++++++++++++++++
 tb/tb_pwm_button_conditioner.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_button_conditioner.sv
// rtl/pwm_button_conditioner.sv - button synchroniser, debouncer and auto-repeat pulse generator for PWM duty control
//
// Ports:
//   clk_i           system clock, all logic on the rising edge
//   rst_i           asynchronous active-high reset
//   enable_i        0 forces the FSM to IDLE and suppresses command pulses
//   btn_inc_raw_i   raw asynchronous increase button
//   btn_dec_raw_i   raw asynchronous decrease button
//   duty_inc_o      one-clk increase command pulse
//   duty_dec_o      one-clk decrease command pulse
//   inc_level_o     debounced increase button level
//   dec_level_o     debounced decrease button level
//   repeat_active_o high while auto-repeating (INC_RPT / DEC_RPT)

module pwm_button_conditioner #(
    parameter int TICK_DIV       = 4,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic btn_inc_raw_i,
    input  logic btn_dec_raw_i,
    output logic duty_inc_o,
    output logic duty_dec_o,
    output logic inc_level_o,
    output logic dec_level_o,
    output logic repeat_active_o
);

    localparam int TW   = $clog2(TICK_DIV + 1);
    localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INC_HOLD = 3'd1,
        INC_RPT  = 3'd2,
        DEC_HOLD = 3'd3,
        DEC_RPT  = 3'd4,
        LOCK     = 3'd5
    } state_t;

    // Two-flop synchronisers; bit 0 = increase, bit 1 = decrease.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_dec_raw_i, btn_inc_raw_i};
            sync2_q <= sync1_q;
        end
    end

    // Free-running slow tick.
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic          fsm_tick_q;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    // The FSM uses the tick delayed by one clk: a first pulse is issued one
    // clk after the debounce tick that raised the level, so the delayed tick
    // makes the repeat interval span whole tick periods from that pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
            fsm_tick_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            fsm_tick_q <= tick;
        end
    end

    // Per-button debounce: the level flips only after DEBOUNCE_TICKS
    // consecutive ticks of disagreement with the synchronised input.
    logic [1:0] level;

    for (genvar b = 0; b < 2; b++) begin : g_debounce
        logic [DW-1:0] cnt_q;
        logic          lvl_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (tick) begin
                if (sync2_q[b] == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                    lvl_q <= ~lvl_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end
        end

        assign level[b] = lvl_q;
    end

    logic inc_lvl;
    logic dec_lvl;
    assign inc_lvl = level[0];
    assign dec_lvl = level[1];

    // Press / auto-repeat FSM.
    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] rpt_cnt_q;
    logic [RW-1:0] rpt_cnt_d;
    logic          duty_inc_q;
    logic          duty_inc_d;
    logic          duty_dec_q;
    logic          duty_dec_d;
    logic          rpt_fire;

    assign rpt_fire = fsm_tick_q && (rpt_cnt_q == RW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rpt_cnt_q  <= '0;
            duty_inc_q <= 1'b0;
            duty_dec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rpt_cnt_q  <= rpt_cnt_d;
            duty_inc_q <= duty_inc_d;
            duty_dec_q <= duty_dec_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inc_lvl && dec_lvl) begin
                        state_d = LOCK;
                    end else if (inc_lvl) begin
                        state_d   = INC_HOLD;
                        rpt_cnt_d = RW'(REPEAT_DELAY);
                    end else if (dec_lvl) begin
                        state_d   = DEC_HOLD;
                        rpt_cnt_d = RW'(REPEAT_DELAY);
                    end
                end
                INC_HOLD, INC_RPT: begin
                    if (!inc_lvl) begin
                        state_d = IDLE;
                    end else if (dec_lvl) begin
                        state_d = LOCK;
                    end else if (rpt_fire) begin
                        state_d   = INC_RPT;
                        rpt_cnt_d = RW'(REPEAT_RATE);
                    end else if (fsm_tick_q) begin
                        rpt_cnt_d = rpt_cnt_q - RW'(1);
                    end
                end
                DEC_HOLD, DEC_RPT: begin
                    if (!dec_lvl) begin
                        state_d = IDLE;
                    end else if (inc_lvl) begin
                        state_d = LOCK;
                    end else if (rpt_fire) begin
                        state_d   = DEC_RPT;
                        rpt_cnt_d = RW'(REPEAT_RATE);
                    end else if (fsm_tick_q) begin
                        rpt_cnt_d = rpt_cnt_q - RW'(1);
                    end
                end
                LOCK: begin
                    // Only a full release leaves LOCK; one button alone never resumes.
                    if (!inc_lvl && !dec_lvl) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Both levels high never produces a pulse, which keeps the two commands exclusive.
    always_comb begin
        duty_inc_d = 1'b0;
        duty_dec_d = 1'b0;
        if (enable_i && !(inc_lvl && dec_lvl)) begin
            if (inc_lvl && ((state_q == IDLE) ||
                            (((state_q == INC_HOLD) || (state_q == INC_RPT)) && rpt_fire))) begin
                duty_inc_d = 1'b1;
            end
            if (dec_lvl && ((state_q == IDLE) ||
                            (((state_q == DEC_HOLD) || (state_q == DEC_RPT)) && rpt_fire))) begin
                duty_dec_d = 1'b1;
            end
        end
    end

    assign duty_inc_o      = duty_inc_q;
    assign duty_dec_o      = duty_dec_q;
    assign inc_level_o     = inc_lvl;
    assign dec_level_o     = dec_lvl;
    assign repeat_active_o = (state_q == INC_RPT) || (state_q == DEC_RPT);

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// tb/tb_pwm_button_conditioner.sv - self-checking bench for pwm_button_conditioner

module tb_pwm_button_conditioner;

    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int REPEAT_DELAY   = 8;
    localparam int REPEAT_RATE    = 2;

    localparam int M_IDLE = 0;
    localparam int M_INC  = 1;
    localparam int M_DEC  = 2;
    localparam int M_LOCK = 3;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic bi;
    logic bd;
    logic duty_inc;
    logic duty_dec;
    logic inc_level;
    logic dec_level;
    logic repeat_active;

    int n_run  = 0;
    int n_fail = 0;

    pwm_button_conditioner #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .btn_inc_raw_i   (bi),
        .btn_dec_raw_i   (bd),
        .duty_inc_o      (duty_inc),
        .duty_dec_o      (duty_dec),
        .inc_level_o     (inc_level),
        .dec_level_o     (dec_level),
        .repeat_active_o (repeat_active)
    );

    always #5 clk = ~clk;

    // Reference model: cycle count since reset gives the tick phase, the
    // raw inputs are seen two edges late, and the hold logic counts ticks
    // upward since the last pulse against the delay or the repeat rate.
    int         m_cyc   = 0;
    logic [1:0] m_h1    = 2'b00;
    logic [1:0] m_h2    = 2'b00;
    logic [1:0] m_lvl   = 2'b00;
    int         m_mis[2];
    logic       m_tick_d = 1'b0;
    int         m_mode  = M_IDLE;
    logic       m_rep   = 1'b0;
    int         m_held  = 0;
    logic       m_pi    = 1'b0;
    logic       m_pd    = 1'b0;

    logic [4:0] m_out;
    logic [4:0] dut_out;
    assign m_out   = {m_pi, m_pd, m_lvl[0], m_lvl[1], m_rep};
    assign dut_out = {duty_inc, duty_dec, inc_level, dec_level, repeat_active};

    task automatic model_step;
        logic tick_now;
        logic fsm_tick;
        logic li;
        logic ld;
        logic own;
        logic other;
        if (rst) begin
            m_cyc = 0; m_h1 = 2'b00; m_h2 = 2'b00; m_lvl = 2'b00;
            m_mis[0] = 0; m_mis[1] = 0; m_tick_d = 1'b0;
            m_mode = M_IDLE; m_rep = 1'b0; m_held = 0; m_pi = 1'b0; m_pd = 1'b0;
        end else begin
            tick_now = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            fsm_tick = m_tick_d;
            li = m_lvl[0];
            ld = m_lvl[1];
            m_pi = 1'b0;
            m_pd = 1'b0;
            if (!enable) begin
                m_mode = M_IDLE;
                m_rep  = 1'b0;
            end else if (m_mode == M_IDLE) begin
                if (li && ld) begin
                    m_mode = M_LOCK;
                end else if (li || ld) begin
                    if (li) m_pi = 1'b1; else m_pd = 1'b1;
                    m_mode = li ? M_INC : M_DEC;
                    m_rep  = 1'b0;
                    m_held = 0;
                end
            end else if (m_mode == M_LOCK) begin
                if (!li && !ld) m_mode = M_IDLE;
            end else begin
                own   = (m_mode == M_INC) ? li : ld;
                other = (m_mode == M_INC) ? ld : li;
                if (!own || other) begin
                    m_mode = own ? M_LOCK : M_IDLE;
                    m_rep  = 1'b0;
                end else if (fsm_tick) begin
                    m_held++;
                    if (m_held == (m_rep ? REPEAT_RATE : REPEAT_DELAY)) begin
                        if (m_mode == M_INC) m_pi = 1'b1; else m_pd = 1'b1;
                        m_rep  = 1'b1;
                        m_held = 0;
                    end
                end
            end
            if (tick_now) begin
                for (int b = 0; b < 2; b++) begin
                    if (m_h2[b] == m_lvl[b]) begin
                        m_mis[b] = 0;
                    end else begin
                        m_mis[b]++;
                        if (m_mis[b] == DEBOUNCE_TICKS) begin
                            m_lvl[b] = ~m_lvl[b];
                            m_mis[b] = 0;
                        end
                    end
                end
            end
            m_h2     = m_h1;
            m_h1     = {bd, bi};
            m_tick_d = tick_now;
            m_cyc++;
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    task automatic test_reset;
        int rise;
        int pulse_at;
        int pulses;
        rst = 1'b1; enable = 1'b1; bi = 1'b1; bd = 1'b1;
        m_mis[0] = 0; m_mis[1] = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b, expected 00000", dut_out);
            end
        end
        rst = 1'b0; bd = 1'b0;
        rise = 0; pulse_at = 0; pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL reset_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (inc_level && rise == 0) rise = i;
            if (duty_inc) begin pulses++; pulse_at = i; end
        end
        n_run++;
        if (rise == 0 || rise > 2 + DEBOUNCE_TICKS * TICK_DIV + TICK_DIV) begin
            n_fail++;
            $display("FAIL reset_level_rise: got cycle %0d, expected 1..%0d", rise,
                     2 + DEBOUNCE_TICKS * TICK_DIV + TICK_DIV);
        end
        n_run++;
        if (pulses !== 1 || pulse_at !== rise + 1) begin
            n_fail++;
            $display("FAIL reset_first_pulse: got %0d pulses at %0d, expected 1 at %0d", pulses, pulse_at, rise + 1);
        end
        bi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL reset_release t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
        end
    endtask

    task automatic test_bounce;
        int pulses;
        int lvl_seen;
        pulses = 0; lvl_seen = 0;
        for (int i = 0; i < 90; i++) begin
            if (i < 60) bi = ((i / 5) % 2 == 0);
            else        bi = 1'b0;
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL bounce_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (duty_inc || duty_dec) pulses++;
            if (inc_level) lvl_seen++;
        end
        n_run++;
        if (pulses !== 0 || lvl_seen !== 0) begin
            n_fail++;
            $display("FAIL bounce_reject: got %0d pulses, %0d level-high cycles, expected 0 and 0", pulses, lvl_seen);
        end
    endtask

    task automatic test_auto_repeat;
        int t[$];
        int rep_rise;
        bd = 1'b1; rep_rise = -1;
        for (int i = 1; i <= 160; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL repeat_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (duty_dec) t.push_back(i);
            if (repeat_active && rep_rise < 0) rep_rise = i;
            if (i == 120) bd = 1'b0;
        end
        n_run++;
        if (t.size() < 3) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d pulses, expected at least 3", t.size());
        end else begin
            n_run++;
            if (t[1] - t[0] !== REPEAT_DELAY * TICK_DIV) begin
                n_fail++;
                $display("FAIL repeat_first_gap: got %0d, expected %0d", t[1] - t[0], REPEAT_DELAY * TICK_DIV);
            end
            for (int k = 2; k < t.size(); k++) begin
                n_run++;
                if (t[k] - t[k-1] !== REPEAT_RATE * TICK_DIV) begin
                    n_fail++;
                    $display("FAIL repeat_rate_gap%0d: got %0d, expected %0d", k, t[k] - t[k-1], REPEAT_RATE * TICK_DIV);
                end
            end
            n_run++;
            if (rep_rise !== t[1]) begin
                n_fail++;
                $display("FAIL repeat_active_rise: got cycle %0d, expected %0d", rep_rise, t[1]);
            end
            n_run++;
            if (t[t.size()-1] > 140 || repeat_active !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat_stop: last pulse %0d, repeat_active %b, expected <=140 and 0", t[t.size()-1], repeat_active);
            end
        end
    endtask

    task automatic test_conflict;
        int late;
        int seen;
        bi = 1'b1;
        late = 0; seen = 0;
        for (int i = 0; i < 65; i++) begin
            if (i == 20) bd = 1'b1;
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL conflict_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (seen != 0 && (duty_inc || duty_dec)) late++;
            seen = m_lvl[1];
        end
        n_run++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL conflict_lock: got %0d pulses after dec level, expected 0", late);
        end
        bi = 1'b0; late = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (duty_inc || duty_dec) late++;
        end
        n_run++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL conflict_one_release: got %0d pulses, expected 0", late);
        end
        bd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        bd = 1'b1; late = 0; seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL conflict_repress_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (duty_dec) late++;
            if (duty_inc) seen++;
        end
        n_run++;
        if (late !== 1 || seen !== 0) begin
            n_fail++;
            $display("FAIL conflict_repress: got %0d dec / %0d inc pulses, expected 1 / 0", late, seen);
        end
        bd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_enable;
        int waited;
        int pulses;
        int gap;
        bi = 1'b1; waited = 0;
        while (!m_rep && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        n_run++;
        if (!m_rep) begin
            n_fail++;
            $display("FAIL enable_reach_repeat: timed out after %0d cycles", waited);
        end
        enable = 1'b0;
        @(posedge clk); #1;
        n_run++;
        if ({duty_inc, duty_dec, repeat_active} !== 3'b000) begin
            n_fail++;
            $display("FAIL enable_off: got %b, expected 000", {duty_inc, duty_dec, repeat_active});
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL enable_off_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (duty_inc || duty_dec) pulses++;
        end
        n_run++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL enable_gated: got %0d pulses, expected 0", pulses);
        end
        // Re-enable on a tick-phase cycle so the repeat delay is a whole number of ticks.
        for (int i = 0; i < TICK_DIV && (m_cyc % TICK_DIV) != 0; i++) begin
            @(posedge clk); #1;
        end
        enable = 1'b1;
        @(posedge clk); #1;
        n_run++;
        if (duty_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_restore_pulse: got %b, expected 1", duty_inc);
        end
        gap = 0;
        for (int i = 1; i <= 50 && gap == 0; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL enable_on_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            if (duty_inc) gap = i;
        end
        n_run++;
        if (gap !== REPEAT_DELAY * TICK_DIV) begin
            n_fail++;
            $display("FAIL enable_restore_gap: got %0d, expected %0d", gap, REPEAT_DELAY * TICK_DIV);
        end
        bi = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_repeat;
        int waited;
        bi = 1'b1; waited = 0;
        while (!m_rep && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        n_run++;
        if (!m_rep) begin
            n_fail++;
            $display("FAIL rstmid_reach_repeat: timed out after %0d cycles", waited);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_run++;
        if (dut_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b, expected 00000", dut_out);
        end
        @(posedge clk); #1;
        n_run++;
        if (dut_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstmid_next_edge: got %b, expected 00000", dut_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 30) bi = 1'b0;
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL rstmid_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
        end
    endtask

    task automatic test_random;
        int seg;
        int pick;
        seg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                pick   = $urandom_range(0, 3);
                bi     = pick[0];
                bd     = pick[1];
                enable = ($urandom_range(0, 9) != 0);
                seg    = $urandom_range(1, 60);
            end
            seg--;
            @(posedge clk); #1;
            n_run++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL random_model t=%0t: got %b, expected %b", $time, dut_out, m_out);
            end
            n_run++;
            if (duty_inc && duty_dec) begin
                n_fail++;
                $display("FAIL random_exclusive t=%0t: got both pulses high, expected at most one", $time);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_auto_repeat();
        test_conflict();
        test_enable();
        test_reset_mid_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
